// File: rtl/scale_down_param.sv
// Raster down-scaler: IMG_W x IMG_H in, (IMG_W/S) x (IMG_H/S) out, box-average or decimate.
// Optional build macro SCALE_ROUND_EN selects round-half-up averaging instead of truncation.
module scale_down_param #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int PIX_W      = 8,
  parameter int SCALE_LOG2 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] in,
  input  logic             avg_mode,
  output logic             ask,
  output logic [PIX_W-1:0] out,
  output logic             display,
  output logic             frame_done
);

  localparam int AW   = PIX_W + 2 * SCALE_LOG2;
  localparam int NBLK = IMG_W >> SCALE_LOG2;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic [PIX_W-1:0] out_q, out_d;
  logic             display_q, display_d;

  logic [AW-1:0]    acc_q [NBLK];

  logic                   capture;
  logic                   col_last, row_last;
  logic                   blk_first, blk_last;
  logic [CW-SCALE_LOG2-1:0] idx;
  logic [AW-1:0]          acc_cur;
  logic [AW-1:0]          sum;
  logic [PIX_W-1:0]       avg_pix;

  assign capture   = (state_q == RUN);
  assign col_last  = (col_q == CW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign blk_first = (row_q[SCALE_LOG2-1:0] == '0) && (col_q[SCALE_LOG2-1:0] == '0);
  assign blk_last  = (row_q[SCALE_LOG2-1:0] == '1) && (col_q[SCALE_LOG2-1:0] == '1);
  assign idx       = col_q[CW-1:SCALE_LOG2];
  assign acc_cur   = acc_q[idx];
  assign sum       = acc_cur + AW'(in);

`ifdef SCALE_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(1) << (2 * SCALE_LOG2 - 1);
  assign avg_pix = PIX_W'((sum + RND) >> (2 * SCALE_LOG2));
`else
  assign avg_pix = PIX_W'(sum >> (2 * SCALE_LOG2));
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    mode_d    = mode_q;
    display_d = 1'b0;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        mode_d  = avg_mode;
        col_d   = '0;
        row_d   = '0;
      end
      RUN: begin
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (col_last && row_last) state_d = DONE;
        // The last pixel of a block never coincides with its load pixel (S >= 2),
        // so the entry already holds the block's partial sum or decimated pixel.
        if (blk_last) begin
          display_d = 1'b1;
          out_d     = mode_q ? avg_pix : acc_cur[PIX_W-1:0];
        end
      end
      DONE: begin
        state_d = RUN;
        mode_d  = avg_mode;
        col_d   = '0;
        row_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 1'b0;
      out_q     <= '0;
      display_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      display_q <= display_d;
    end
  end

  // Entries are re-initialised at every block-row start, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      if (blk_first) begin
        acc_q[idx] <= AW'(in);
      end else if (mode_q) begin
        acc_q[idx] <= sum;
      end
    end
  end

  assign ask        = (state_q == RUN);
  assign frame_done = (state_q == DONE);
  assign out        = out_q;
  assign display    = display_q;

endmodule

// File: tb/tb_scale_down_param.sv
// Directed bench for scale_down_param: default 128x128/2x instance plus a 16x16/4x instance.
module tb_scale_down_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       avg_mode;
  logic       ask;
  logic [7:0] pix_out;
  logic       display;
  logic       frame_done;

  logic       rst2_n;
  logic [7:0] in2;
  logic       mode2;
  logic       ask2;
  logic [7:0] out2;
  logic       disp2;
  logic       fd2;

  int n_vec = 0;
  int n_err = 0;
  bit small_done = 1'b0;

  always #5 clk = ~clk;

  scale_down_param dut (
    .clk(clk), .reset(rst_n), .in(pix_in), .avg_mode(avg_mode),
    .ask(ask), .out(pix_out), .display(display), .frame_done(frame_done)
  );

  scale_down_param #(.IMG_W(16), .IMG_H(16), .PIX_W(8), .SCALE_LOG2(2)) dut4 (
    .clk(clk), .reset(rst2_n), .in(in2), .avg_mode(mode2),
    .ask(ask2), .out(out2), .display(disp2), .frame_done(fd2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    if (pat == 0) begin
      if (r < 2 && c < 2) return 8'(1 + r * 2 + c);
      if (r < 2 && c < 4) return 8'd255;
      return 8'd100;
    end
    return 8'((r * 128 + c) & 255);
  endfunction

  function automatic logic [7:0] exp_out(input int pat, input bit mode, input int k);
    int r, c, s;
    r = 2 * (k / 64);
    c = 2 * (k % 64);
    if (!mode) return pix(pat, r, c);
    s = pix(pat, r, c) + pix(pat, r, c + 1) + pix(pat, r + 1, c) + pix(pat, r + 1, c + 1);
`ifdef SCALE_ROUND_EN
    s = s + 2;
`endif
    return 8'(s >> 2);
  endfunction

  // Drives one frame (or stop_after pixels of one) and scores the outputs it produces.
  task automatic run_frame(input int pat, input bit mode, input int stop_after,
                           input bit toggle, input string tag);
    int p, k, fd, asklow, errs;
    bit seen_ask, disp_at_fd;
    logic [7:0] first_exp;
    p = 0; k = 0; fd = 0; asklow = 0; errs = 0; seen_ask = 0; disp_at_fd = 0;
`ifdef SCALE_ROUND_EN
    first_exp = 8'd3;
`else
    first_exp = 8'd2;
`endif
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (display) begin
        if (pat == 0 && mode && k == 0) chk({tag, "_blk1234"}, pix_out, first_exp);
        if (pat == 0 && mode && k == 1) chk({tag, "_blk255"}, pix_out, 8'd255);
        if (pix_out !== exp_out(pat, mode, k)) errs++;
        k++;
      end
      if (frame_done) begin
        fd++;
        disp_at_fd = display;
      end
      if (seen_ask && !ask) asklow++;
      if (ask) begin
        seen_ask = 1;
        pix_in = pix(pat, p / 128, p % 128);
        p++;
        if (toggle && p == 5000) avg_mode = ~mode;
        if (toggle && p == 10000) avg_mode = mode;
      end
      if (frame_done) break;
      if (stop_after > 0 && p == stop_after) break;
    end
    if (stop_after == 0) begin
      chk({tag, "_pulses"}, k, 4096);
      chk({tag, "_out_errs"}, errs, 0);
      chk({tag, "_frame_done"}, fd, 1);
      chk({tag, "_disp_with_done"}, disp_at_fd, 1);
      chk({tag, "_ask_low"}, asklow, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pix_in = '0;
    avg_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ask", ask, 0);
      chk("rst_display", display, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_out", pix_out, 0);
    end
    rst_n = 1'b1;
    #1 chk("rel_ask0", ask, 0);
    @(posedge clk);
    #1 chk("rel_ask1", ask, 1);

    run_frame(0, 1'b1, 0, 1'b0, "avg");
    avg_mode = 1'b0;
    run_frame(1, 1'b0, 0, 1'b1, "dec");
    avg_mode = 1'b1;
    run_frame(1, 1'b1, 1000, 1'b0, "partial");

    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_display", display, 0);
      chk("midrst_out", pix_out, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midrst_ask1", ask, 1);
    run_frame(1, 1'b1, 0, 1'b0, "post_rst");

    for (int i = 0; i < 2000 && !small_done; i++) @(negedge clk);
    chk("small_done", small_done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [7:0] ramp_exp [4];
    int p2, k2, nfd, lat_err;
    bit prev_last;
    ramp_exp = '{8'd24, 8'd88, 8'd152, 8'd216};
    p2 = 0; k2 = 0; nfd = 0; lat_err = 0; prev_last = 0;
    rst2_n = 1'b0;
    mode2 = 1'b1;
    in2 = '0;
    repeat (3) @(negedge clk);
    rst2_n = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (disp2 !== prev_last) lat_err++;
      if (disp2) begin
        chk($sformatf("s4_out%0d", k2), out2, ramp_exp[k2 % 4]);
        k2++;
      end
      if (fd2) nfd++;
      prev_last = 0;
      if (ask2) begin
        in2 = 8'((p2 % 16) * 16);
        prev_last = (((p2 / 16) % 4) == 3) && ((p2 % 4) == 3);
        p2++;
      end
      if (nfd == 2) break;
    end
    chk("s4_pulses", k2, 32);
    chk("s4_frame_done", nfd, 2);
    chk("s4_latency_errs", lat_err, 0);
    small_done = 1'b1;
  end

endmodule
